// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: widths, operand-fetch FSM encoding and
// the ID/EX payload carried to the ALU.
package cpu_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 8;

  localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } fetch_state_e;

  // Registered operands and register-file control for one EX instruction
  typedef struct packed {
    logic [XLEN-1:0]  opA;
    logic [XLEN-1:0]  opB;
    logic [XLEN-1:0]  imm;
    logic [REG_W-1:0] dst;
    logic             regWrite;
    logic             memRead;
  } ex_payload_t;

  // A later stage can supply src when it really writes a non-zero register
  function automatic logic fwdHit(input logic             valid,
                                  input logic             regWrite,
                                  input logic [REG_W-1:0] dst,
                                  input logic [REG_W-1:0] src);
    return valid && regWrite && (dst != ZERO_REG) && (dst == src);
  endfunction

endpackage

// File: rtl/bypass_mux.sv
// Resolves one source operand: EX/MEM result, then MEM/WB data, then the
// hardwired zero register, then register-file read data.
module bypass_mux
  import cpu_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic [XLEN-1:0]  rfData,
  input  logic             emValid,
  input  logic             emRegWrite,
  input  logic [REG_W-1:0] emDst,
  input  logic [XLEN-1:0]  emResult,
  input  logic             mwValid,
  input  logic             mwRegWrite,
  input  logic [REG_W-1:0] mwDst,
  input  logic [XLEN-1:0]  mwResult,
  output logic [XLEN-1:0]  operand_c
);

  // MEM/WB path is required: the register file cannot forward its own write
  always_comb begin
    operand_c = rfData;
    if (fwdHit(emValid, emRegWrite, emDst, src)) begin
      operand_c = emResult;
    end else if (fwdHit(mwValid, mwRegWrite, mwDst, src)) begin
      operand_c = mwResult;
    end else if (src == ZERO_REG) begin
      operand_c = '0;
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// ID/EX boundary: operand bypassing, load-use bubble insertion, the ID/EX
// pipeline register and a saturating load-use stall counter.
module operand_fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned CTRL_W = cpu_pkg::CTRL_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [XLEN-1:0]   rf_data1,
  input  logic [XLEN-1:0]   rf_data2,
  input  logic              em_valid,
  input  logic              em_reg_write,
  input  logic [REG_W-1:0]  em_dst,
  input  logic [XLEN-1:0]   em_result,
  input  logic              mw_valid,
  input  logic              mw_reg_write,
  input  logic [REG_W-1:0]  mw_dst,
  input  logic [XLEN-1:0]   mw_result,
  input  logic              ex_hold,
  input  logic              flush,
  output logic              stall_ifid,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_op_a,
  output logic [XLEN-1:0]   ex_op_b,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_W-1:0]  ex_dst,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  stall_count
);

  fetch_state_e      stateQ;
  fetch_state_e      stateD;
  ex_payload_t       exQ;
  ex_payload_t       exD;
  logic              exValidQ;
  logic [CTRL_W-1:0] ctrlQ;
  logic [CNT_W-1:0]  stallCntQ;
  logic [XLEN-1:0]   opA_c;
  logic [XLEN-1:0]   opB_c;
  logic              hazard_c;
  logic              loadBubble_c;
  logic              capture_c;

  bypass_mux u_bypassA (
    .src        (id_rs),
    .rfData     (rf_data1),
    .emValid    (em_valid),
    .emRegWrite (em_reg_write),
    .emDst      (em_dst),
    .emResult   (em_result),
    .mwValid    (mw_valid),
    .mwRegWrite (mw_reg_write),
    .mwDst      (mw_dst),
    .mwResult   (mw_result),
    .operand_c  (opA_c)
  );

  bypass_mux u_bypassB (
    .src        (id_rt),
    .rfData     (rf_data2),
    .emValid    (em_valid),
    .emRegWrite (em_reg_write),
    .emDst      (em_dst),
    .emResult   (em_result),
    .mwValid    (mw_valid),
    .mwRegWrite (mw_reg_write),
    .mwDst      (mw_dst),
    .mwResult   (mw_result),
    .operand_c  (opB_c)
  );

  // A load sitting in EX cannot forward until it reaches EX/MEM
  assign hazard_c = exValidQ && exQ.memRead && (exQ.dst != ZERO_REG) && id_valid &&
                    ((exQ.dst == id_rs) || (exQ.dst == id_rt));

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      stateQ <= ST_RUN;
    end else begin
      stateQ <= stateD;
    end
  end

  // Priority: flush, then ex_hold, then load-use hazard
  always_comb begin
    stateD = stateQ;
    if (flush) begin
      stateD = ST_RUN;
    end else if (ex_hold) begin
      stateD = stateQ;
    end else if ((stateQ == ST_RUN) && hazard_c) begin
      stateD = ST_BUBBLE;
    end else begin
      stateD = ST_RUN;
    end
  end

  always_comb begin
    stall_ifid   = 1'b0;
    loadBubble_c = 1'b0;
    capture_c    = 1'b0;
    if (Reset && !flush) begin
      if (ex_hold) begin
        stall_ifid = 1'b1;
      end else if ((stateQ == ST_RUN) && hazard_c) begin
        stall_ifid   = 1'b1;
        loadBubble_c = 1'b1;
      end else begin
        capture_c = 1'b1;
      end
    end
  end

  always_comb begin
    exD          = '0;
    exD.opA      = opA_c;
    exD.opB      = opB_c;
    exD.imm      = id_imm;
    exD.dst      = id_dst;
    exD.regWrite = id_reg_write;
    exD.memRead  = id_mem_read;
  end

  // ID/EX register and stall counter; flush and ex_hold leave payload as is
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      exValidQ  <= 1'b0;
      exQ       <= '0;
      ctrlQ     <= '0;
      stallCntQ <= '0;
    end else if (flush) begin
      exValidQ <= 1'b0;
    end else if (loadBubble_c) begin
      exValidQ <= 1'b0;
      if (stallCntQ != '1) begin
        stallCntQ <= stallCntQ + CNT_W'(1);
      end
    end else if (capture_c) begin
      exValidQ <= id_valid;
      exQ      <= exD;
      ctrlQ    <= id_ctrl;
    end
  end

  assign ex_valid     = exValidQ;
  assign ex_op_a      = exQ.opA;
  assign ex_op_b      = exQ.opB;
  assign ex_imm       = exQ.imm;
  assign ex_dst       = exQ.dst;
  assign ex_reg_write = exQ.regWrite;
  assign ex_mem_read  = exQ.memRead;
  assign ex_ctrl      = ctrlQ;
  assign stall_count  = stallCntQ;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage: directed hazard/bypass scenarios
// followed by random traffic, checked against a behavioural pipeline model.
module tb_operand_fetch_stage;

  localparam int unsigned CW = 8;

  typedef struct {
    logic        rstn;
    logic        idValid;
    logic [4:0]  rs, rt, dst;
    logic        rw, mr;
    logic [31:0] imm;
    logic [7:0]  ctrl;
    logic [31:0] rf1, rf2;
    logic        emV, emRw;
    logic [4:0]  emDst;
    logic [31:0] emRes;
    logic        mwV, mwRw;
    logic [4:0]  mwDst;
    logic [31:0] mwRes;
    logic        hold, flush;
  } stim_t;

  typedef struct {
    logic        rst;
    logic        v;
    logic [31:0] a, b, imm;
    logic [4:0]  dst;
    logic        rw, mr;
    logic [7:0]  ctrl;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  logic          CLK = 1'b0;
  logic          Reset = 1'b0;
  logic          id_valid = 1'b0;
  logic [4:0]    id_rs = '0, id_rt = '0, id_dst = '0;
  logic          id_reg_write = 1'b0, id_mem_read = 1'b0;
  logic [31:0]   id_imm = '0;
  logic [CW-1:0] id_ctrl = '0;
  logic [31:0]   rf_data1 = '0, rf_data2 = '0;
  logic          em_valid = 1'b0, em_reg_write = 1'b0;
  logic [4:0]    em_dst = '0;
  logic [31:0]   em_result = '0;
  logic          mw_valid = 1'b0, mw_reg_write = 1'b0;
  logic [4:0]    mw_dst = '0;
  logic [31:0]   mw_result = '0;
  logic          ex_hold = 1'b0, flush = 1'b0;

  logic          stall_ifid, ex_valid, ex_reg_write, ex_mem_read;
  logic [31:0]   ex_op_a, ex_op_b, ex_imm;
  logic [4:0]    ex_dst;
  logic [CW-1:0] ex_ctrl;
  logic [15:0]   stall_count;

  logic          satStall, satValid, satRw, satMr;
  logic [31:0]   satA, satB, satImm;
  logic [4:0]    satDst;
  logic [CW-1:0] satCtrl;
  logic [1:0]    satCnt;

  int nVec = 0;
  int nErr = 0;
  exp_t sbQ[$];

  // Reference pipeline state
  logic        mValid = 1'b0, mRw = 1'b0, mMr = 1'b0, mInBubble = 1'b0;
  logic [31:0] mA = '0, mB = '0, mImm = '0;
  logic [4:0]  mDst = '0;
  logic [7:0]  mCtrl = '0;
  logic [15:0] mCnt = '0;
  logic [1:0]  mCnt2 = '0;

  always #5 CLK = ~CLK;

  operand_fetch_stage #(.CTRL_W(CW), .CNT_W(16)) dut (
    .CLK(CLK), .Reset(Reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_dst(id_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_imm(id_imm), .id_ctrl(id_ctrl), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .em_valid(em_valid), .em_reg_write(em_reg_write), .em_dst(em_dst), .em_result(em_result),
    .mw_valid(mw_valid), .mw_reg_write(mw_reg_write), .mw_dst(mw_dst), .mw_result(mw_result),
    .ex_hold(ex_hold), .flush(flush), .stall_ifid(stall_ifid), .ex_valid(ex_valid),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_imm(ex_imm), .ex_dst(ex_dst),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_ctrl(ex_ctrl),
    .stall_count(stall_count)
  );

  operand_fetch_stage #(.CTRL_W(CW), .CNT_W(2)) dutSat (
    .CLK(CLK), .Reset(Reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_dst(id_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_imm(id_imm), .id_ctrl(id_ctrl), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .em_valid(em_valid), .em_reg_write(em_reg_write), .em_dst(em_dst), .em_result(em_result),
    .mw_valid(mw_valid), .mw_reg_write(mw_reg_write), .mw_dst(mw_dst), .mw_result(mw_result),
    .ex_hold(ex_hold), .flush(flush), .stall_ifid(satStall), .ex_valid(satValid),
    .ex_op_a(satA), .ex_op_b(satB), .ex_imm(satImm), .ex_dst(satDst),
    .ex_reg_write(satRw), .ex_mem_read(satMr), .ex_ctrl(satCtrl),
    .stall_count(satCnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Youngest producer wins; r0 is always zero
  function automatic logic [31:0] resolve(input stim_t s, input logic [4:0] src, input logic [31:0] rf);
    if (s.emV && s.emRw && s.emDst != 5'd0 && s.emDst == src) return s.emRes;
    if (s.mwV && s.mwRw && s.mwDst != 5'd0 && s.mwDst == src) return s.mwRes;
    if (src == 5'd0) return 32'h0;
    return rf;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{rstn: 1'b1, idValid: 1'b0, rs: 5'd0, rt: 5'd0, dst: 5'd0, rw: 1'b0, mr: 1'b0,
          imm: 32'h0, ctrl: 8'h0, rf1: 32'h0, rf2: 32'h0, emV: 1'b0, emRw: 1'b0,
          emDst: 5'd0, emRes: 32'h0, mwV: 1'b0, mwRw: 1'b0, mwDst: 5'd0, mwRes: 32'h0,
          hold: 1'b0, flush: 1'b0};
    return s;
  endfunction

  function automatic stim_t rndStim();
    stim_t s;
    s = idle();
    s.rstn    = ($urandom_range(99) >= 2);
    s.idValid = ($urandom_range(9) < 8);
    s.rs      = 5'($urandom_range(7));
    s.rt      = 5'($urandom_range(7));
    s.dst     = 5'($urandom_range(7));
    s.rw      = ($urandom_range(9) < 7);
    s.mr      = ($urandom_range(9) < 4);
    s.imm     = $urandom;
    s.ctrl    = 8'($urandom);
    s.rf1     = $urandom;
    s.rf2     = $urandom;
    s.emV     = ($urandom_range(3) != 0);
    s.emRw    = ($urandom_range(3) != 0);
    s.emDst   = 5'($urandom_range(7));
    s.emRes   = $urandom;
    s.mwV     = ($urandom_range(3) != 0);
    s.mwRw    = ($urandom_range(3) != 0);
    s.mwDst   = 5'($urandom_range(7));
    s.mwRes   = $urandom;
    s.hold    = ($urandom_range(99) < 8);
    s.flush   = ($urandom_range(99) < 5);
    return s;
  endfunction

  task automatic apply(input stim_t s);
    Reset = s.rstn; id_valid = s.idValid; id_rs = s.rs; id_rt = s.rt; id_dst = s.dst;
    id_reg_write = s.rw; id_mem_read = s.mr; id_imm = s.imm; id_ctrl = s.ctrl;
    rf_data1 = s.rf1; rf_data2 = s.rf2;
    em_valid = s.emV; em_reg_write = s.emRw; em_dst = s.emDst; em_result = s.emRes;
    mw_valid = s.mwV; mw_reg_write = s.mwRw; mw_dst = s.mwDst; mw_result = s.mwRes;
    ex_hold = s.hold; flush = s.flush;
  endtask

  // One cycle: drive, check the combinational stall, advance the model, queue expectation
  task automatic step(input stim_t s);
    logic hz, stallExp;
    exp_t e;
    @(negedge CLK);
    apply(s);
    #1;
    hz = mValid && mMr && (mDst != 5'd0) && s.idValid && ((mDst == s.rs) || (mDst == s.rt));
    stallExp = s.rstn && !s.flush && (s.hold || (!mInBubble && hz));
    check("stall_ifid", 32'(stall_ifid), 32'(stallExp));
    if (!s.rstn) begin
      mValid = 0; mA = '0; mB = '0; mImm = '0; mDst = '0; mRw = 0; mMr = 0; mCtrl = '0;
      mInBubble = 0; mCnt = '0; mCnt2 = '0;
    end else if (s.flush) begin
      mValid = 0; mInBubble = 0;
    end else if (s.hold) begin
      mValid = mValid;
    end else if (!mInBubble && hz) begin
      mValid = 0; mInBubble = 1;
      if (mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
      if (mCnt2 != 2'd3) mCnt2 = mCnt2 + 2'd1;
    end else begin
      mValid = s.idValid; mA = resolve(s, s.rs, s.rf1); mB = resolve(s, s.rt, s.rf2);
      mImm = s.imm; mDst = s.dst; mRw = s.rw; mMr = s.mr; mCtrl = s.ctrl; mInBubble = 0;
    end
    e = '{rst: !s.rstn, v: mValid, a: mA, b: mB, imm: mImm, dst: mDst, rw: mRw, mr: mMr,
          ctrl: mCtrl, cnt: mCnt, cnt2: mCnt2};
    sbQ.push_back(e);
  endtask

  // Monitor: compare registered outputs after every active edge
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sbQ.size() != 0) begin
        e = sbQ.pop_front();
        check("ex_valid", 32'(ex_valid), 32'(e.v));
        check("sat_ex_valid", 32'(satValid), 32'(e.v));
        check("stall_count", 32'(stall_count), 32'(e.cnt));
        check("sat_stall_count", 32'(satCnt), 32'(e.cnt2));
        if (e.v || e.rst) begin
          check("ex_op_a", ex_op_a, e.a);
          check("ex_op_b", ex_op_b, e.b);
          check("ex_imm", ex_imm, e.imm);
          check("ex_dst", 32'(ex_dst), 32'(e.dst));
          check("ex_reg_write", 32'(ex_reg_write), 32'(e.rw));
          check("ex_mem_read", 32'(ex_mem_read), 32'(e.mr));
          check("ex_ctrl", 32'(ex_ctrl), 32'(e.ctrl));
        end
      end
    end
  end

  task automatic drain();
    @(posedge CLK);
    #2;
    check("scoreboard_empty", 32'(sbQ.size()), 32'd0);
  endtask

  stim_t ld, dep, s;

  initial begin
    s = idle(); s.rstn = 1'b0;
    step(s); step(s);

    // Bypass priority on rs=3: EX/MEM, then MEM/WB, then register file
    s = idle(); s.idValid = 1; s.rs = 3; s.rt = 4; s.dst = 7; s.rw = 1;
    s.imm = 32'h1234; s.ctrl = 8'h5A; s.rf1 = 32'h33; s.rf2 = 32'h44;
    s.emV = 1; s.emRw = 1; s.emDst = 3; s.emRes = 32'h11;
    s.mwV = 1; s.mwRw = 1; s.mwDst = 3; s.mwRes = 32'h22;
    step(s);
    s.emV = 0; step(s);
    s.mwV = 0; step(s);

    // r0 never forwards
    s = idle(); s.idValid = 1; s.rs = 0; s.rf1 = 32'h99;
    s.emV = 1; s.emRw = 1; s.emDst = 0; s.emRes = 32'hFFFF;
    step(s);

    // Load-use on both rs and rt: one bubble, then issue with EX/MEM forwarding
    ld = idle(); ld.idValid = 1; ld.rs = 1; ld.dst = 5; ld.rw = 1; ld.mr = 1; ld.imm = 32'h40;
    dep = idle(); dep.idValid = 1; dep.rs = 5; dep.rt = 5; dep.dst = 6; dep.rw = 1;
    dep.rf1 = 32'hDEAD; dep.rf2 = 32'hBEEF; dep.ctrl = 8'hC3;
    step(ld); step(dep);
    dep.emV = 1; dep.emRw = 1; dep.emDst = 5; dep.emRes = 32'hABCD;
    step(dep);

    // Flush while in bubble
    dep.emV = 0;
    step(ld); step(dep);
    s = dep; s.flush = 1; step(s);
    step(idle());

    // ex_hold for three cycles with changing decode, then flush during hold
    s = idle(); s.idValid = 1; s.rs = 2; s.rt = 3; s.dst = 4; s.rw = 1;
    s.rf1 = 32'h1111; s.rf2 = 32'h2222; s.imm = 32'h7; s.ctrl = 8'h11;
    step(s);
    for (int i = 0; i < 3; i++) begin
      s.hold = 1; s.rf1 = $urandom; s.imm = $urandom; s.dst = 5'(i + 8);
      step(s);
    end
    s.flush = 1; step(s);
    step(idle());

    // Reset during a load-use stall
    step(ld);
    s = dep; s.rstn = 0; step(s);
    step(idle());

    // Counter saturation in the 2-bit instance
    for (int i = 0; i < 5; i++) begin
      step(ld); step(dep); step(dep);
    end
    drain();
    check("sat_count_final", 32'(satCnt), 32'd3);
    check("stall_count_final", 32'(stall_count), 32'd5);

    for (int i = 0; i < 3000; i++) step(rndStim());
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/operand_fetch_stage.md
# operand_fetch_stage

ID/EX boundary of the pipelined CPU: consumes register-file read data for the instruction in decode and resolves operand bypassing from the EX/MEM and MEM/WB stages. It detects load-use hazards, stalls IF/ID and inserts a bubble, and registers the resolved operands and control into the ID/EX pipeline register that feeds the ALU. It also keeps a saturating stall counter for performance debug.

## Interface
- CTRL_W, 8, width of opaque decoded control bundle passed to EX
- CNT_W, 16, width of stall counter
- CLK  in  1  clock, all state updates on rising edge
- Reset  in  1  reset, synchronous, active-low
- id_valid  in  1  decode slot holds a real instruction
- id_rs, id_rt  in  5  source register numbers
- id_dst  in  5  destination register number
- id_reg_write, id_mem_read  in  1  instruction writes a register / is a load
- id_imm  in  32  sign/zero-extended immediate
- id_ctrl  in  CTRL_W  decoded control for EX
- rf_data1, rf_data2  in  32  register-file read data for id_rs / id_rt
- em_valid, em_reg_write  in  1  EX/MEM stage qualifiers
- em_dst  in  5; em_result  in  32  EX/MEM destination and ALU result
- mw_valid, mw_reg_write  in  1  MEM/WB qualifiers
- mw_dst  in  5; mw_result  in  32  MEM/WB destination and writeback data
- ex_hold  in  1  EX cannot accept (multi-cycle op); freeze this stage
- flush  in  1  branch/jump redirect; kill decode slot and ID/EX contents
- stall_ifid  out  1  hold PC and IF/ID register this cycle
- ex_valid  out  1; ex_op_a, ex_op_b, ex_imm  out  32; ex_dst  out  5
- ex_reg_write, ex_mem_read  out  1; ex_ctrl  out  CTRL_W
- stall_count  out  CNT_W  cycles spent in load-use stall, saturating

## Operation
- Bypass per operand (rs -> op_a, rt -> op_b), priority high to low:
  - em_valid & em_reg_write & em_dst != 0 & em_dst == src -> em_result
  - mw_valid & mw_reg_write & mw_dst != 0 & mw_dst == src -> mw_result
  - src == 0 -> 32'h0; else rf_data.
- The register file gives no same-cycle write-to-read guarantee; the MEM/WB bypass is mandatory, not an optimisation.
- Load-use hazard: ex_valid & ex_mem_read & ex_dst != 0 & id_valid & (ex_dst == id_rs | ex_dst == id_rt).
- FSM, two states:
  - RUN: on hazard (and no flush/ex_hold) -> load bubble (ex_valid=0, other ex_* don't-care), assert stall_ifid, go BUBBLE.
  - BUBBLE: load now in EX/MEM, so forwarding resolves it; capture the decode slot normally, return to RUN.
- stall_ifid = hazard in RUN, or ex_hold; combinational.
- ex_hold: all ex_* registers, FSM and counter hold.
- flush: ex_valid <= 0, FSM -> RUN, stall_ifid deasserted. Priority order: flush beats ex_hold, which beats hazard.
- stall_count increments once per bubble inserted; saturates at all-ones.

## Timing
- Latency 1 cycle: ID inputs at edge N appear on ex_* after edge N.
- Load-use costs exactly one bubble cycle.
- Reset (Reset==0 at edge): ex_valid=0, all ex_* data/control=0, FSM=RUN, stall_count=0. stall_ifid=0 while in reset.
- Reset mid-stall discards the held decode slot; upstream is reset in the same cycle.
- id_valid=0 captures as a bubble, not a hazard.
- Hazard on both rs and rt against the same load gives one bubble only.

## Structure
- Shared cpu_pkg: REG_W=5, XLEN=32, CTRL_W, FSM state encoding (ST_RUN, ST_BUBBLE), ZERO_REG=5'd0.
- One sub-module: bypass_mux (combinational, one instance per operand); FSM, hazard and registers stay in top.

## Test plan
- Bypass priority: em_dst=mw_dst=id_rs=3, em_result=0x11, mw_result=0x22, rf_data1=0x33 -> ex_op_a=0x11 next cycle; drop em_valid -> 0x22.
- $zero: id_rs=0, em_dst=0, em_result=0xFFFF -> ex_op_a=0.
- Load-use: lw to r5 in EX, id_rt=5 -> one cycle ex_valid=0, stall_ifid=1, stall_count=1. Next cycle the instruction issues with op_b=em_result.
- Flush during BUBBLE: ex_valid=0, FSM=RUN, stall_ifid=0.
- ex_hold for 3 cycles -> ex_* unchanged and stall_ifid=1 throughout; flush during hold clears ex_valid.
- Reset: Reset=0 for one edge mid-stall -> all outputs 0, stall_count=0. Counter saturation is checked with CNT_W=2 after 5 bubbles -> 3.
